// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_fetch_pkg
// Purpose  : Shared constants and types for the instruction-fetch stage.
//            fetch_slot_t is the common {valid, pc, inst} record used for
//            both the skid buffer and the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
package rv_fetch_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_slot_t;

    // Value a slot takes out of reset: empty, PC zero, NOP payload.
    localparam fetch_slot_t SLOT_RESET = '{valid: 1'b0, pc: '0, inst: NOP_INST};

endpackage : rv_fetch_pkg
`default_nettype wire

// File: rtl/if_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_skid_reg
// Purpose  : Single-entry fetch slot register with load / clear / hold.
//            clear drops only the valid bit; pc and inst keep their last
//            value. clear has priority over load.
// Ports    : clk      in   clock (rising edge)
//            reset    in   asynchronous active-high reset
//            load_i   in   capture slot_i
//            clear_i  in   invalidate the slot
//            slot_i   in   fetch_slot_t to capture
//            slot_o   out  current slot contents
// Revision : 1.0 - initial release
// ============================================================================
module if_skid_reg
    import rv_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  fetch_slot_t slot_i,
    output fetch_slot_t slot_o
);

    fetch_slot_t slot_q;
    fetch_slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d.valid = 1'b0;
        end else if (load_i) begin
            slot_d = slot_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= SLOT_RESET;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule : if_skid_reg
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch with IF/ID register. Sequential PC generation,
//            requests to a synchronous-read (1-cycle) instruction memory, a
//            one-entry skid buffer that parks the response arriving during a
//            decode stall, and flush of wrong-path fetches on EX redirect.
//            Per-cycle priority: redirect > stall > normal.
// Ports    : clk          in   clock (rising edge)
//            reset        in   asynchronous active-high reset
//            imem_req     out  fetch issued this cycle
//            imem_addr    out  fetch address, word aligned
//            imem_rdata   in   instruction for last cycle's request
//            stall        in   decode cannot accept; hold IF/ID
//            redirect     in   control-flow change resolved in EX
//            redirect_pc  in   new fetch address (bits [1:0] ignored)
//            if_id_valid  out  IF/ID holds a live instruction
//            if_id_pc     out  PC of if_id_inst
//            if_id_inst   out  instruction to decode
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              if_id_valid,
    output logic [31:0]       if_id_pc,
    output logic [INST_W-1:0] if_id_inst
);

    // PC sequencer and in-flight tracking
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        infl_v_q,   infl_v_d;
    logic [31:0] infl_pc_q,  infl_pc_d;

    // Slot controls
    fetch_slot_t w_resp;
    fetch_slot_t skid_q;
    fetch_slot_t ifid_q;
    fetch_slot_t ifid_in;
    logic        skid_load, skid_clear;
    logic        ifid_load, ifid_clear;
    logic        w_normal;

    // Alignment bits of the redirect target are dropped by design.
    logic        w_unused_lsbs;
    assign w_unused_lsbs = ^redirect_pc[1:0];

    always_comb begin
        w_normal  = ~redirect & ~stall;

        // A redirect always issues, even under stall; otherwise issue only
        // when decode is accepting. Nothing is issued while in reset.
        imem_req  = ~reset & (redirect | ~stall);
        imem_addr = redirect ? {redirect_pc[31:2], 2'b00} : fetch_pc_q;

        fetch_pc_d = fetch_pc_q;
        infl_pc_d  = infl_pc_q;
        infl_v_d   = imem_req;
        if (imem_req) begin
            fetch_pc_d = imem_addr + 32'd4;   // wraps naturally at 2^32
            infl_pc_d  = imem_addr;
        end

        // Response for the request issued last cycle.
        w_resp = '{valid: 1'b1, pc: infl_pc_q, inst: imem_rdata};

        // Skid: park the arriving response under stall; empty it on redirect
        // or when it drains into IF/ID. A stall issues nothing, so the
        // single entry can never be asked to hold two responses.
        skid_load  = ~redirect & stall & infl_v_q;
        skid_clear = redirect | (w_normal & skid_q.valid);

        // IF/ID: parked response takes precedence over the memory port.
        ifid_load  = w_normal & (skid_q.valid | infl_v_q);
        ifid_clear = redirect | (w_normal & ~skid_q.valid & ~infl_v_q);
        ifid_in    = skid_q.valid ? skid_q : w_resp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            infl_v_q   <= 1'b0;
            infl_pc_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_v_q   <= infl_v_d;
            infl_pc_q  <= infl_pc_d;
        end
    end

    if_skid_reg u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .slot_i  (w_resp),
        .slot_o  (skid_q)
    );

    if_skid_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ifid_load),
        .clear_i (ifid_clear),
        .slot_i  (ifid_in),
        .slot_o  (ifid_q)
    );

    assign if_id_valid = ifid_q.valid;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_inst  = ifid_q.inst;

    // A parked response and a fresh response can never compete for IF/ID.
    a_skid_no_collision : assert property (
        @(posedge clk) disable iff (reset)
        (!redirect && !stall) |-> !(skid_q.valid && infl_v_q)
    );

endmodule : if_fetch_stage
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Directed self-checking bench for if_fetch_stage. A one-cycle
//            synchronous memory model returns inst_of(addr) for each request
//            (0xDEADBEEF when no request was made).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    int n_checks = 0;
    int n_fail   = 0;

    // One table row = one cycle: inputs, then expected outputs.
    typedef struct packed {
        logic        st;
        logic        rd;
        logic [31:0] rp;
        logic        eq;
        logic [31:0] ea;
        logic        ev;
        logic [31:0] ep;
    } vec_t;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    always @(posedge clk) begin
        imem_rdata <= imem_req ? inst_of(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", if_id_pc); end
        n_checks++; if (if_id_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h want 00000013", if_id_inst); end
        cyc();
        reset = 1'b0;   // cycle 0 starts here
    endtask

    // Cycles 0..9: sequential fetch, then a 3-cycle stall in cycles 3..5.
    task automatic test_stream_stall();
        vec_t v [10];
        v[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0};
        v[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'h0};
        v[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h0};
        v[3] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 32'h4};
        v[4] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 32'h4};
        v[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 32'h4};
        v[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h4};
        v[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h8};
        v[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'hC};
        v[9] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h18, 1'b1, 32'h10};
        for (int i = 0; i < 10; i++) begin
            stall = v[i].st; redirect = v[i].rd; redirect_pc = v[i].rp;
            #1;
            n_checks++; if (imem_req !== v[i].eq) begin n_fail++; $display("FAIL stream c%0d req: got %b want %b", i, imem_req, v[i].eq); end
            if (v[i].eq) begin n_checks++; if (imem_addr !== v[i].ea) begin n_fail++; $display("FAIL stream c%0d addr: got %h want %h", i, imem_addr, v[i].ea); end end
            n_checks++; if (if_id_valid !== v[i].ev) begin n_fail++; $display("FAIL stream c%0d valid: got %b want %b", i, if_id_valid, v[i].ev); end
            if (v[i].ev) begin n_checks++; if ({if_id_pc, if_id_inst} !== {v[i].ep, inst_of(v[i].ep)}) begin n_fail++; $display("FAIL stream c%0d pc/inst: got %h/%h want %h/%h", i, if_id_pc, if_id_inst, v[i].ep, inst_of(v[i].ep)); end end
            cyc();
        end
    endtask

    // Cycles 10..13: redirect to 0x103 in cycle 10.
    task automatic test_redirect();
        vec_t v [4];
        v[0] = '{1'b0, 1'b1, 32'h103, 1'b1, 32'h100, 1'b1, 32'h14};
        v[1] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
        v[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};
        v[3] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104};
        for (int i = 0; i < 4; i++) begin
            stall = v[i].st; redirect = v[i].rd; redirect_pc = v[i].rp;
            #1;
            n_checks++; if (imem_req !== v[i].eq) begin n_fail++; $display("FAIL redirect c%0d req: got %b want %b", i, imem_req, v[i].eq); end
            if (v[i].eq) begin n_checks++; if (imem_addr !== v[i].ea) begin n_fail++; $display("FAIL redirect c%0d addr: got %h want %h", i, imem_addr, v[i].ea); end end
            n_checks++; if (if_id_valid !== v[i].ev) begin n_fail++; $display("FAIL redirect c%0d valid: got %b want %b", i, if_id_valid, v[i].ev); end
            if (v[i].ev) begin n_checks++; if ({if_id_pc, if_id_inst} !== {v[i].ep, inst_of(v[i].ep)}) begin n_fail++; $display("FAIL redirect c%0d pc/inst: got %h/%h want %h/%h", i, if_id_pc, if_id_inst, v[i].ep, inst_of(v[i].ep)); end end
            cyc();
        end
    endtask

    // Cycles 14..18: stall fills the skid, then redirect + stall together.
    task automatic test_redirect_stall();
        vec_t v [5];
        v[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b1, 32'h108};
        v[1] = '{1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h108};
        v[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
        v[3] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200};
        v[4] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b1, 32'h204};
        for (int i = 0; i < 5; i++) begin
            stall = v[i].st; redirect = v[i].rd; redirect_pc = v[i].rp;
            #1;
            n_checks++; if (imem_req !== v[i].eq) begin n_fail++; $display("FAIL redir_stall c%0d req: got %b want %b", i, imem_req, v[i].eq); end
            if (v[i].eq) begin n_checks++; if (imem_addr !== v[i].ea) begin n_fail++; $display("FAIL redir_stall c%0d addr: got %h want %h", i, imem_addr, v[i].ea); end end
            n_checks++; if (if_id_valid !== v[i].ev) begin n_fail++; $display("FAIL redir_stall c%0d valid: got %b want %b", i, if_id_valid, v[i].ev); end
            if (v[i].ev) begin n_checks++; if ({if_id_pc, if_id_inst} !== {v[i].ep, inst_of(v[i].ep)}) begin n_fail++; $display("FAIL redir_stall c%0d pc/inst: got %h/%h want %h/%h", i, if_id_pc, if_id_inst, v[i].ep, inst_of(v[i].ep)); end end
            cyc();
        end
    endtask

    // Cycles 19..22: redirect to 0xFFFFFFFF (aligned to ...FC), PC wraps to 0.
    task automatic test_wrap();
        vec_t v [4];
        v[0] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h208};
        v[1] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0};
        v[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
        v[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0};
        for (int i = 0; i < 4; i++) begin
            stall = v[i].st; redirect = v[i].rd; redirect_pc = v[i].rp;
            #1;
            n_checks++; if (imem_req !== v[i].eq) begin n_fail++; $display("FAIL wrap c%0d req: got %b want %b", i, imem_req, v[i].eq); end
            if (v[i].eq) begin n_checks++; if (imem_addr !== v[i].ea) begin n_fail++; $display("FAIL wrap c%0d addr: got %h want %h", i, imem_addr, v[i].ea); end end
            n_checks++; if (if_id_valid !== v[i].ev) begin n_fail++; $display("FAIL wrap c%0d valid: got %b want %b", i, if_id_valid, v[i].ev); end
            if (v[i].ev) begin n_checks++; if ({if_id_pc, if_id_inst} !== {v[i].ep, inst_of(v[i].ep)}) begin n_fail++; $display("FAIL wrap c%0d pc/inst: got %h/%h want %h/%h", i, if_id_pc, if_id_inst, v[i].ep, inst_of(v[i].ep)); end end
            cyc();
        end
    endtask

    // Reset asserted mid-cycle while streaming, then a clean restart.
    task automatic test_mid_reset();
        vec_t v [4];
        stall = 1'b0; redirect = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", if_id_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midreset_req: got %b want 0", imem_req); end
        n_checks++; if (if_id_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL midreset_inst: got %h want 00000013", if_id_inst); end
        cyc();
        cyc();
        reset = 1'b0;
        v[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0};
        v[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'h0};
        v[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h0};
        v[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h4};
        for (int i = 0; i < 4; i++) begin
            stall = v[i].st; redirect = v[i].rd; redirect_pc = v[i].rp;
            #1;
            n_checks++; if (imem_req !== v[i].eq) begin n_fail++; $display("FAIL restart c%0d req: got %b want %b", i, imem_req, v[i].eq); end
            if (v[i].eq) begin n_checks++; if (imem_addr !== v[i].ea) begin n_fail++; $display("FAIL restart c%0d addr: got %h want %h", i, imem_addr, v[i].ea); end end
            n_checks++; if (if_id_valid !== v[i].ev) begin n_fail++; $display("FAIL restart c%0d valid: got %b want %b", i, if_id_valid, v[i].ev); end
            if (v[i].ev) begin n_checks++; if ({if_id_pc, if_id_inst} !== {v[i].ep, inst_of(v[i].ep)}) begin n_fail++; $display("FAIL restart c%0d pc/inst: got %h/%h want %h/%h", i, if_id_pc, if_id_inst, v[i].ep, inst_of(v[i].ep)); end end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_stream_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_if_fetch_stage
`default_nettype wire
